// File: rtl/tic_tac_toe_game.sv
// Two-player 3x3 tic-tac-toe core: one cell selection per clock, alternating marks,
// combinational win/draw decode of the registered board.
module tic_tac_toe_game (
    input  logic        clock,
    input  logic        reset,
    input  logic [50:0] user_input,
    input  logic        set_x_or_o,
    output logic [1:0]  pos1,
    output logic [1:0]  pos2,
    output logic [1:0]  pos3,
    output logic [1:0]  pos4,
    output logic [1:0]  pos5,
    output logic [1:0]  pos6,
    output logic [1:0]  pos7,
    output logic [1:0]  pos8,
    output logic [1:0]  pos9,
    output logic [1:0]  result,
    output logic        x_or_o
);
    localparam int NUM_CELLS = 9;

    logic [NUM_CELLS-1:0][1:0] board;
    logic [NUM_CELLS-1:0]      hit;
    logic [7:0][1:0]           line_owner;
    logic [1:0]                win;
    logic                      full;
    logic                      accept;

    // A cell is hit only by an exact full-width match on an empty cell, so
    // out-of-range or unknown selections never place a mark.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_hit
        assign hit[i] = (user_input == 51'(i + 1)) && (board[i] == 2'b00);
    end

    assign accept = (|hit) && (result == 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            board  <= '0;
            x_or_o <= set_x_or_o;
        end else if (accept) begin
            for (int i = 0; i < NUM_CELLS; i++)
                if (hit[i]) board[i] <= x_or_o ? 2'b10 : 2'b01;
            x_or_o <= ~x_or_o;
        end
    end

    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return ((a == b) && (b == c)) ? a : 2'b00;
    endfunction

    assign line_owner[0] = line3(board[0], board[1], board[2]);
    assign line_owner[1] = line3(board[3], board[4], board[5]);
    assign line_owner[2] = line3(board[6], board[7], board[8]);
    assign line_owner[3] = line3(board[0], board[3], board[6]);
    assign line_owner[4] = line3(board[1], board[4], board[7]);
    assign line_owner[5] = line3(board[2], board[5], board[8]);
    assign line_owner[6] = line3(board[0], board[4], board[8]);
    assign line_owner[7] = line3(board[2], board[4], board[6]);

    always_comb begin
        win  = 2'b00;
        full = 1'b1;
        for (int l = 0; l < 8; l++)
            if (win == 2'b00) win = line_owner[l];
        for (int i = 0; i < NUM_CELLS; i++)
            if (board[i] == 2'b00) full = 1'b0;
    end

    // Win outranks draw when the ninth mark also completes a line.
    assign result = (win != 2'b00) ? win : (full ? 2'b11 : 2'b00);

    assign pos1 = board[0];
    assign pos2 = board[1];
    assign pos3 = board[2];
    assign pos4 = board[3];
    assign pos5 = board[4];
    assign pos6 = board[5];
    assign pos7 = board[6];
    assign pos8 = board[7];
    assign pos9 = board[8];
endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Bench for tic_tac_toe_game: directed game scenarios plus random play,
// all compared against a cell-array game model.
module tb_tic_tac_toe_game;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [50:0] user_input = '0;
    logic        set_x_or_o = 1'b0;
    logic [1:0]  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0]  result;
    logic        x_or_o;

    int checks = 0;
    int failures = 0;

    tic_tac_toe_game dut (
        .clock(clock), .reset(reset), .user_input(user_input), .set_x_or_o(set_x_or_o),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .result(result), .x_or_o(x_or_o)
    );

    always #5 clock = ~clock;

    logic [1:0] pos_o [9];
    assign pos_o[0] = pos1; assign pos_o[1] = pos2; assign pos_o[2] = pos3;
    assign pos_o[3] = pos4; assign pos_o[4] = pos5; assign pos_o[5] = pos6;
    assign pos_o[6] = pos7; assign pos_o[7] = pos8; assign pos_o[8] = pos9;

    // Model: cell owner 0 empty, 1 X, 2 O; turn 0 X, 1 O.
    int m_cell [9];
    int m_turn;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int model_result();
        int filled = 0;
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] != 0 && m_cell[lines[l][0]] == m_cell[lines[l][1]]
                && m_cell[lines[l][1]] == m_cell[lines[l][2]])
                return m_cell[lines[l][0]];
        for (int i = 0; i < 9; i++) if (m_cell[i] != 0) filled++;
        return (filled == 9) ? 3 : 0;
    endfunction

    task automatic model_apply(input logic rst, input logic start, input logic [50:0] in);
        if (rst) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            m_turn = int'(start);
        end else if (in >= 1 && in <= 9 && model_result() == 0 && m_cell[int'(in) - 1] == 0) begin
            m_cell[int'(in) - 1] = (m_turn == 1) ? 2 : 1;
            m_turn = 1 - m_turn;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string where);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s pos%0d", where, i + 1), pos_o[i], 2'(m_cell[i]));
        chk({where, " result"}, result, 2'(model_result()));
        chk({where, " x_or_o"}, {1'b0, x_or_o}, 2'(m_turn));
    endtask

    task automatic step(input logic rst, input logic start, input logic [50:0] in,
                        input string where);
        reset = rst; set_x_or_o = start; user_input = in;
        @(posedge clock);
        model_apply(rst, start, in);
        #1;
        check_all(where);
    endtask

    task automatic play(input logic start, input int seq [], input string where);
        step(1'b1, start, 51'd0, {where, " reset"});
        for (int k = 0; k < seq.size(); k++)
            step(1'b0, 1'b0, 51'(seq[k]), $sformatf("%s mv%0d", where, k));
    endtask

    initial begin
        logic [50:0] rin;
        int rst_pick;

        // 1: reset state for both starting players
        step(1'b1, 1'b1, 51'd0, "t1 rst O");
        chk("t1 x_or_o=1", {1'b0, x_or_o}, 2'd1);
        chk("t1 result=0", result, 2'b00);
        step(1'b1, 1'b0, 51'd0, "t1 rst X");
        chk("t1 x_or_o=0", {1'b0, x_or_o}, 2'd0);

        // 2: O wins top row
        play(1'b1, '{1, 4, 2, 5, 3}, "t2");
        chk("t2 result O", result, 2'b10);
        chk("t2 pos3 O", pos3, 2'b10);
        chk("t2 pos5 X", pos5, 2'b01);
        chk("t2 x_or_o", {1'b0, x_or_o}, 2'd0);

        // 3: frozen after the win
        for (int k = 0; k < 7; k++) begin
            int frz [7] = '{6, 2, 9, 5, 1, 8, 0};
            step(1'b0, 1'b0, 51'(frz[k]), $sformatf("t3 mv%0d", k));
        end
        chk("t3 pos6 empty", pos6, 2'b00);
        chk("t3 result O", result, 2'b10);

        // 4: occupied and out-of-range selections
        play(1'b0, '{5, 5, 0, 12, 7}, "t4");
        chk("t4 pos5 X", pos5, 2'b01);
        chk("t4 pos7 O", pos7, 2'b10);
        chk("t4 x_or_o", {1'b0, x_or_o}, 2'd0);

        // 5: draw on the ninth move
        play(1'b0, '{1, 2, 3, 5, 4, 6, 8, 7}, "t5");
        chk("t5 result pre", result, 2'b00);
        step(1'b0, 1'b0, 51'd9, "t5 mv8");
        chk("t5 result draw", result, 2'b11);
        chk("t5 pos9 X", pos9, 2'b01);
        chk("t5 pos7 O", pos7, 2'b10);

        // 6: reset beats a valid move in the same cycle
        play(1'b0, '{1, 2}, "t6");
        step(1'b1, 1'b1, 51'd3, "t6 rst+mv");
        chk("t6 pos3 empty", pos3, 2'b00);
        chk("t6 pos1 empty", pos1, 2'b00);
        chk("t6 x_or_o", {1'b0, x_or_o}, 2'd1);

        // Random play with occasional resets and wide garbage inputs
        for (int n = 0; n < 600; n++) begin
            rst_pick = int'($urandom_range(0, 24));
            case ($urandom_range(0, 9))
                0:       rin = {19'($urandom), $urandom};
                1:       rin = 51'($urandom_range(10, 15));
                default: rin = 51'($urandom_range(0, 9));
            endcase
            step(rst_pick == 0, 1'($urandom), rin, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
